wb_stage: RTL and testbench

//  Write-back stage; consumes the memory-stage-2 pipeline outputs (flag, reg index, thread index, data).

---
 rtl/wb_stage.sv | 97 +++++++++
 tb/tb_wb_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: registers the memory-stage-2 result into the WB pipeline
// register, commits it to a multithreaded register file on the following edge,
// and serves two combinational read ports with bypass from the WB register.
module wb_stage #(
    parameter int DATA_WIDTH        = 64,
    parameter int REG_INDEX_BITS    = 5,
    parameter int THREAD_INDEX_BITS = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_write_back_flag,
    input  logic [REG_INDEX_BITS-1:0]    in_reg_index,
    input  logic [THREAD_INDEX_BITS-1:0] in_thread_index,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [THREAD_INDEX_BITS-1:0] rd_thread_index,
    input  logic [REG_INDEX_BITS-1:0]    rd_a_index,
    input  logic [REG_INDEX_BITS-1:0]    rd_b_index,
    output logic [DATA_WIDTH-1:0]        rd_a_data,
    output logic [DATA_WIDTH-1:0]        rd_b_data,
    output logic                         out_wb_valid,
    output logic [REG_INDEX_BITS-1:0]    out_wb_reg_index,
    output logic [THREAD_INDEX_BITS-1:0] out_wb_thread_index,
    output logic [DATA_WIDTH-1:0]        out_wb_data,
    output logic [31:0]                  out_commit_count
);

    // Flat storage addressed by {thread, reg}; threads never alias.
    localparam int ADDR_BITS = THREAD_INDEX_BITS + REG_INDEX_BITS;
    localparam int ENTRIES   = 1 << ADDR_BITS;

    logic [DATA_WIDTH-1:0] regs [ENTRIES];
    logic [ENTRIES-1:0]    written;
    logic [ADDR_BITS-1:0]  commit_addr;

    assign commit_addr = {out_wb_thread_index, out_wb_reg_index};

    // WB pipeline register: fields always load, reg 0 writes are dropped here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_wb_valid        <= 1'b0;
            out_wb_reg_index    <= '0;
            out_wb_thread_index <= '0;
            out_wb_data         <= '0;
        end else begin
            out_wb_valid        <= in_write_back_flag && (in_reg_index != '0);
            out_wb_reg_index    <= in_reg_index;
            out_wb_thread_index <= in_thread_index;
            out_wb_data         <= in_data;
        end
    end

    // Register storage is deliberately not reset; the written bits gate reads.
    always_ff @(posedge clk) begin
        if (out_wb_valid) begin
            regs[commit_addr] <= out_wb_data;
        end
    end

    // Per-entry written bits and the wrapping commit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written          <= '0;
            out_commit_count <= '0;
        end else if (out_wb_valid) begin
            written[commit_addr] <= 1'b1;
            out_commit_count     <= out_commit_count + 32'd1;
        end
    end

    // Read priority: reg 0, WB bypass, committed value, never-written zero.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [REG_INDEX_BITS-1:0] idx
    );
        logic [ADDR_BITS-1:0] addr;
        addr = {rd_thread_index, idx};
        if (idx == '0) begin
            return '0;
        end else if (out_wb_valid && (out_wb_thread_index == rd_thread_index)
                     && (out_wb_reg_index == idx)) begin
            return out_wb_data;
        end else if (written[addr]) begin
            return regs[addr];
        end
        return '0;
    endfunction

    // Read port A.
    always_comb begin
        rd_a_data = read_port(rd_a_index);
    end

    // Read port B.
    always_comb begin
        rd_b_data = read_port(rd_b_index);
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vectors with literal expectations, plus a
// behavioural model compared against every output on each falling edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_write_back_flag = 1'b0;
    logic [4:0]  in_reg_index = '0;
    logic [2:0]  in_thread_index = '0;
    logic [63:0] in_data = '0;
    logic [2:0]  rd_thread_index = '0;
    logic [4:0]  rd_a_index = '0;
    logic [4:0]  rd_b_index = '0;
    logic [63:0] rd_a_data, rd_b_data, out_wb_data;
    logic        out_wb_valid;
    logic [4:0]  out_wb_reg_index;
    logic [2:0]  out_wb_thread_index;
    logic [31:0] out_commit_count;

    int total = 0;
    int bad   = 0;

    wb_stage #(.DATA_WIDTH(64), .REG_INDEX_BITS(5), .THREAD_INDEX_BITS(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_write_back_flag(in_write_back_flag), .in_reg_index(in_reg_index),
        .in_thread_index(in_thread_index), .in_data(in_data),
        .rd_thread_index(rd_thread_index), .rd_a_index(rd_a_index), .rd_b_index(rd_b_index),
        .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
        .out_wb_valid(out_wb_valid), .out_wb_reg_index(out_wb_reg_index),
        .out_wb_thread_index(out_wb_thread_index), .out_wb_data(out_wb_data),
        .out_commit_count(out_commit_count)
    );

    always #5 clk = ~clk;

    // Model: one pending op, a thread x reg memory with written flags, a counter.
    logic        m_pv;
    logic [4:0]  m_pr;
    logic [2:0]  m_pt;
    logic [63:0] m_pd;
    logic [31:0] m_cnt;
    logic [63:0] m_mem [8][32];
    bit          m_wr  [8][32];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pv <= 1'b0; m_pr <= '0; m_pt <= '0; m_pd <= '0; m_cnt <= '0;
            for (int t = 0; t < 8; t++)
                for (int r = 0; r < 32; r++)
                    m_wr[t][r] <= 1'b0;
        end else begin
            if (m_pv) begin
                m_mem[m_pt][m_pr] <= m_pd;
                m_wr[m_pt][m_pr]  <= 1'b1;
                m_cnt             <= m_cnt + 32'd1;
            end
            m_pv <= in_write_back_flag && (in_reg_index != 5'd0);
            m_pr <= in_reg_index;
            m_pt <= in_thread_index;
            m_pd <= in_data;
        end
    end

    function automatic logic [63:0] m_read(input logic [2:0] t, input logic [4:0] r);
        if (r == 5'd0) return 64'd0;
        if (m_pv && m_pt == t && m_pr == r) return m_pd;
        if (m_wr[t][r]) return m_mem[t][r];
        return 64'd0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every output against the model, every falling edge.
    always @(negedge clk) begin
        check("model_wb_valid", {63'd0, out_wb_valid}, {63'd0, m_pv});
        check("model_wb_reg", {59'd0, out_wb_reg_index}, {59'd0, m_pr});
        check("model_wb_thread", {61'd0, out_wb_thread_index}, {61'd0, m_pt});
        check("model_wb_data", out_wb_data, m_pd);
        check("model_count", {32'd0, out_commit_count}, {32'd0, m_cnt});
        check("model_rd_a", rd_a_data, m_read(rd_thread_index, rd_a_index));
        check("model_rd_b", rd_b_data, m_read(rd_thread_index, rd_b_index));
    end

    // Inputs change 2 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic f, input logic [2:0] t, input logic [4:0] r,
                          input logic [63:0] d);
        in_write_back_flag = f; in_thread_index = t; in_reg_index = r; in_data = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        rst_n = 1'b1;

        // 1. After reset everything reads zero.
        check("reset_valid", {63'd0, out_wb_valid}, 64'd0);
        check("reset_count", {32'd0, out_commit_count}, 64'd0);
        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < 32; r++) begin
                rd_thread_index = t[2:0];
                rd_a_index = r[4:0];
                rd_b_index = 5'(31 - r);
                tick();
                check("reset_rd_a", rd_a_data, 64'd0);
                check("reset_rd_b", rd_b_data, 64'd0);
            end
        end

        // 2. Single write: bypass next cycle, regfile after.
        rd_thread_index = 3'd2; rd_a_index = 5'd5; rd_b_index = 5'd5;
        set_in(1'b1, 3'd2, 5'd5, 64'hDEAD);
        tick();
        set_in(1'b0, 3'd0, 5'd0, 64'd0);
        check("t2_bypass", rd_a_data, 64'hDEAD);
        check("t2_valid", {63'd0, out_wb_valid}, 64'd1);
        tick();
        check("t2_regfile", rd_a_data, 64'hDEAD);
        check("t2_count", {32'd0, out_commit_count}, 64'd1);
        tick();
        check("t2_regfile_b", rd_b_data, 64'hDEAD);

        // 3. Write to reg 0 is dropped.
        rd_a_index = 5'd0;
        set_in(1'b1, 3'd2, 5'd0, 64'h1234);
        tick();
        set_in(1'b0, 3'd0, 5'd0, 64'd0);
        check("t3_valid", {63'd0, out_wb_valid}, 64'd0);
        check("t3_wb_data", out_wb_data, 64'h1234);
        check("t3_rd_r0", rd_a_data, 64'd0);
        tick();
        check("t3_count", {32'd0, out_commit_count}, 64'd1);

        // 4. Back-to-back same reg; later write wins; other thread isolated.
        do_reset();
        rd_thread_index = 3'd1; rd_a_index = 5'd7; rd_b_index = 5'd7;
        set_in(1'b1, 3'd1, 5'd7, 64'h11);
        tick();
        set_in(1'b1, 3'd1, 5'd7, 64'h22);
        check("t4_bypass1", rd_a_data, 64'h11);
        tick();
        set_in(1'b0, 3'd0, 5'd0, 64'd0);
        check("t4_bypass2", rd_a_data, 64'h22);
        tick();
        check("t4_regfile", rd_a_data, 64'h22);
        rd_thread_index = 3'd3;
        #1;
        check("t4_other_thread", rd_a_data, 64'd0);
        check("t4_count", {32'd0, out_commit_count}, 64'd2);

        // 5. Flag low: fields load but nothing commits.
        rd_thread_index = 3'd0; rd_a_index = 5'd4;
        set_in(1'b0, 3'd0, 5'd4, 64'hFF);
        tick();
        set_in(1'b0, 3'd0, 5'd0, 64'd0);
        check("t5_wb_data", out_wb_data, 64'hFF);
        check("t5_valid", {63'd0, out_wb_valid}, 64'd0);
        check("t5_rd", rd_a_data, 64'd0);
        tick();
        check("t5_count", {32'd0, out_commit_count}, 64'd2);

        // Boundary: thread 7, reg 31, then a mixed burst under the model.
        rd_thread_index = 3'd7; rd_a_index = 5'd31; rd_b_index = 5'd30;
        set_in(1'b1, 3'd7, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        set_in(1'b0, 3'd0, 5'd0, 64'd0);
        tick();
        check("edge_t7_r31", rd_a_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("edge_t7_r30", rd_b_data, 64'd0);
        for (int i = 0; i < 48; i++) begin
            set_in((i % 3) != 0, 3'(i % 4), 5'((i * 7) % 8), 64'(i) * 64'h0101_0101_0101_0101);
            rd_thread_index = 3'((i + 1) % 4);
            rd_a_index = 5'((i * 3) % 8);
            rd_b_index = 5'((i * 5 + 1) % 8);
            tick();
        end
        set_in(1'b0, 3'd0, 5'd0, 64'd0);
        tick();

        // 6. Reset asserted before the commit edge loses the pending write.
        do_reset();
        rd_thread_index = 3'd0; rd_a_index = 5'd9;
        set_in(1'b1, 3'd0, 5'd9, 64'h99);
        tick();
        set_in(1'b0, 3'd0, 5'd0, 64'd0);
        check("t6_valid_before", {63'd0, out_wb_valid}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_valid_async", {63'd0, out_wb_valid}, 64'd0);
        tick();
        rst_n = 1'b1;
        check("t6_rd", rd_a_data, 64'd0);
        check("t6_count", {32'd0, out_commit_count}, 64'd0);
        tick();
        check("t6_rd_later", rd_a_data, 64'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
